// File: rtl/chopper_ref_gen_pkg.sv
// Shared types and constants for the chopper reference generator.
package chopper_ref_gen_pkg;

  // Default width of the period and phase counters.
  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDelay   = 2'd1,
    StRunHigh = 2'd2,
    StRunLow  = 2'd3
  } state_e;

endpackage

// File: rtl/chopper_period_cnt.sv
// Loadable up-counter with a terminal-count flag. Clears to zero, counts up to
// i_term and holds there, so it can never wrap.
module chopper_period_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_term,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;

  // Count register: clear has priority, increment saturates at the terminal value.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != i_term)) begin
      r_cnt <= r_cnt + CntOne;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_term);

endmodule

// File: rtl/chopper_ref_gen.sv
// Square-wave reference generator for a synchronous chopper.
// Optional quadrature output is built only when CHOPPER_QUAD_EN is defined;
// otherwise chopper_q is tied low.
// All outputs are registered from the current state, so they trail the state
// register by one cycle.
module chopper_ref_gen
  import chopper_ref_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             enable,
  input  logic [CNT_W-1:0] half_period,
  input  logic [CNT_W-1:0] phase_offset,
  input  logic             load,
  output logic             cfg_ack,
  output logic             chopper_sig,
  output logic             chopper_q,
  output logic             cycle_strobe,
  output logic             active
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  logic [CNT_W-1:0] r_shadow_n;
  logic [CNT_W-1:0] r_shadow_p;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_p;
  logic             r_pend;
  logic             r_stop;
  logic             r_sig;
  logic             r_strobe;
  logic             r_active;
  logic             r_ack;

  logic [CNT_W-1:0] w_ne_m1;
  logic [CNT_W-1:0] w_pe_m1;
  logic [CNT_W-1:0] w_cfg_n;
  logic [CNT_W-1:0] w_cfg_p;
  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_d_cnt;
  logic             w_run;
  logic             w_h_clr;
  logic             w_h_inc;
  logic             w_h_tc;
  logic             w_d_clr;
  logic             w_d_inc;
  logic             w_d_tc;
  logic             w_stop_nxt;
  logic             w_boundary;
  logic             w_apply;

  // Terminal values, counter controls and config hand-over decision.
  always_comb begin
    w_run   = (r_state == StRunHigh) || (r_state == StRunLow);
    // N = 0 behaves as N = 1.
    w_ne_m1 = (r_n == '0) ? '0 : (r_n - CntOne);
    // Only used in DELAY, where P is known to be non-zero.
    w_pe_m1 = r_p - CntOne;
    w_h_clr = !w_run || w_h_tc;
    w_h_inc = w_run && !w_h_tc;
    w_d_clr = (r_state != StDelay) || w_d_tc;
    w_d_inc = (r_state == StDelay) && !w_d_tc;
    // Stop request follows enable while running; re-asserting enable cancels it.
    w_stop_nxt = r_stop;
    if (w_run) begin
      w_stop_nxt = !enable;
    end else begin
      w_stop_nxt = 1'b0;
    end
    w_boundary = (r_state == StRunLow) && w_h_tc && !w_stop_nxt;
    // New config only lands between periods, never mid half-period.
    w_apply    = r_pend && ((r_state == StIdle) || w_boundary);
    w_cfg_n    = w_apply ? r_shadow_n : r_n;
    w_cfg_p    = w_apply ? r_shadow_p : r_p;
  end

  chopper_period_cnt #(
    .CNT_W (CNT_W)
  ) u_half_cnt (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .i_clr    (w_h_clr),
    .i_inc    (w_h_inc),
    .i_term   (w_ne_m1),
    .o_cnt    (w_h_cnt),
    .o_tc     (w_h_tc)
  );

  chopper_period_cnt #(
    .CNT_W (CNT_W)
  ) u_delay_cnt (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .i_clr    (w_d_clr),
    .i_inc    (w_d_inc),
    .i_term   (w_pe_m1),
    .o_cnt    (w_d_cnt),
    .o_tc     (w_d_tc)
  );

  // The delay count value itself is not needed, only its terminal flag.
  logic w_unused_d_cnt;
  assign w_unused_d_cnt = ^w_d_cnt;

`ifdef CHOPPER_QUAD_EN
  logic             r_q;
  logic [CNT_W-1:0] w_q_dly;
  // floor(Ne/2); N = 0 and N = 1 both give zero lag.
  assign w_q_dly = r_n >> 1;
`else
  logic w_unused_h_cnt;
  assign w_unused_h_cnt = ^w_h_cnt;
`endif

  // Main FSM with config shadowing, stop handling and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= StIdle;
      r_shadow_n <= '0;
      r_shadow_p <= '0;
      r_n        <= '0;
      r_p        <= '0;
      r_pend     <= 1'b0;
      r_stop     <= 1'b0;
      r_sig      <= 1'b0;
      r_strobe   <= 1'b0;
      r_active   <= 1'b0;
      r_ack      <= 1'b0;
`ifdef CHOPPER_QUAD_EN
      r_q        <= 1'b0;
`endif
    end else begin
      if (load) begin
        r_shadow_n <= half_period;
        r_shadow_p <= phase_offset;
      end
      // A load coinciding with an apply stays pending for the next boundary.
      r_pend   <= load || (r_pend && !w_apply);
      r_n      <= w_cfg_n;
      r_p      <= w_cfg_p;
      r_stop   <= w_stop_nxt;
      r_ack    <= w_apply;
      r_sig    <= (r_state == StRunHigh);
      r_strobe <= (r_state == StRunLow) && w_h_tc;
      r_active <= (r_state != StIdle);
`ifdef CHOPPER_QUAD_EN
      // Position t in the period: high half t = cnt, low half t = Ne + cnt.
      r_q      <= ((r_state == StRunHigh) && (w_h_cnt >= w_q_dly)) ||
                  ((r_state == StRunLow) && (w_h_cnt < w_q_dly));
`endif
      case (r_state)
        StIdle: begin
          if (enable) begin
            r_state <= (w_cfg_p != '0) ? StDelay : StRunHigh;
          end
        end
        StDelay: begin
          if (!enable) begin
            r_state <= StIdle;
          end else if (w_d_tc) begin
            r_state <= StRunHigh;
          end
        end
        StRunHigh: begin
          if (w_h_tc) begin
            r_state <= StRunLow;
          end
        end
        StRunLow: begin
          if (w_h_tc) begin
            r_state <= w_stop_nxt ? StIdle : StRunHigh;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign chopper_sig  = r_sig;
  assign cycle_strobe = r_strobe;
  assign active       = r_active;
  assign cfg_ack      = r_ack;
`ifdef CHOPPER_QUAD_EN
  assign chopper_q    = r_q;
`else
  assign chopper_q    = 1'b0;
`endif

endmodule

// File: tb/tb_chopper_ref_gen.sv
// Self-checking bench for chopper_ref_gen: a vector table for the basic run
// plus directed sequences for delay, zero period, config update, stop and reset.
module tb_chopper_ref_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] half_period;
  logic [15:0] phase_offset;
  logic        load;
  logic        cfg_ack;
  logic        chopper_sig;
  logic        chopper_q;
  logic        cycle_strobe;
  logic        active;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  chopper_ref_gen #(
    .CNT_W (16)
  ) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .enable       (enable),
    .half_period  (half_period),
    .phase_offset (phase_offset),
    .load         (load),
    .cfg_ack      (cfg_ack),
    .chopper_sig  (chopper_sig),
    .chopper_q    (chopper_q),
    .cycle_strobe (cycle_strobe),
    .active       (active)
  );

  typedef struct {
    logic        en;
    logic        ld;
    logic [15:0] n;
    logic [15:0] p;
    logic        sig;
    logic        stb;
    logic        act;
    logic        ack;
    logic        q;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Quadrature output only exists with the macro; otherwise it must stay 0.
  function automatic logic q_exp(input logic model_q);
`ifdef CHOPPER_QUAD_EN
    return model_q;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all(input string tag, input logic sig, input logic stb,
                           input logic act, input logic ack, input logic q);
    check({tag, " sig"}, chopper_sig, sig);
    check({tag, " strobe"}, cycle_strobe, stb);
    check({tag, " active"}, active, act);
    check({tag, " ack"}, cfg_ack, ack);
    check({tag, " q"}, chopper_q, q_exp(q));
  endtask

  // Expected outputs k cycles after enable; sig first high at cycle 'start'.
  task automatic exp_period(input int k, input int start, input int ne,
                            output logic sig, output logic stb, output logic q);
    int m;
    if (k < start) begin
      sig = 1'b0;
      stb = 1'b0;
      q   = 1'b0;
    end else begin
      m   = (k - start) % (2 * ne);
      sig = (m < ne);
      stb = (m == 2 * ne - 1);
      q   = (m >= ne / 2) && (m < ne + ne / 2);
    end
  endtask

  task automatic step(input logic en, input logic ld, input logic [15:0] n,
                      input logic [15:0] p);
    @(negedge clk);
    enable       = en;
    load         = ld;
    half_period  = n;
    phase_offset = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    load   = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
  endtask

  // Reset, then load and let IDLE apply the config.
  task automatic setup(input logic [15:0] n, input logic [15:0] p);
    do_reset();
    step(1'b0, 1'b1, n, p);
    step(1'b0, 1'b0, n, p);
  endtask

  initial begin
    logic s, b, q;

    // en ld  n      p      sig   stb   act   ack   q
    vecs[0]  = '{1'b0, 1'b1, 16'd4, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 16'd4, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'd4, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'd4, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 16'd4, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 16'd4, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 16'd4, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 16'd4, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 16'd4, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 16'd4, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 16'd4, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 16'd4, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 16'd4, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 16'd4, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 16'd4, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 16'd4, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 16'd4, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 16'd4, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 16'd4, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state, asynchronously and with the clock running.
    rst_n        = 1'b0;
    enable       = 1'b0;
    load         = 1'b0;
    half_period  = '0;
    phase_offset = '0;
    #1;
    check_all("reset async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset clocked", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic run N=4, P=0.
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].en, vecs[i].ld, vecs[i].n, vecs[i].p);
      check_all($sformatf("basic step=%0d", i), vecs[i].sig, vecs[i].stb,
                vecs[i].act, vecs[i].ack, vecs[i].q);
    end

    // Phase delay P=3, N=2: three DELAY cycles then a 2/2 pattern.
    setup(16'd2, 16'd3);
    for (int k = 1; k <= 14; k++) begin
      step(1'b1, 1'b0, 16'd2, 16'd3);
      exp_period(k, 5, 2, s, b, q);
      check_all($sformatf("delay k=%0d", k), s, b, k >= 2, 1'b0, q);
    end

    // N=0 behaves as N=1.
    setup(16'd0, 16'd0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, 16'd0, 16'd0);
      exp_period(k, 2, 1, s, b, q);
      check_all($sformatf("n0 k=%0d", k), s, b, k >= 2, 1'b0, q);
    end

    // Config update mid RUN_HIGH: 4/4 finishes, ack at the boundary, then 6/6.
    setup(16'd4, 16'd0);
    for (int k = 1; k <= 22; k++) begin
      step(1'b1, k == 3, (k == 3) ? 16'd6 : 16'd4, 16'd0);
      if (k < 10) exp_period(k, 2, 4, s, b, q);
      else exp_period(k, 10, 6, s, b, q);
      check_all($sformatf("cfg k=%0d", k), s, b, k >= 2, k == 9, q);
    end

    // Stop one cycle into RUN_HIGH with N=5: period completes, then idle.
    setup(16'd5, 16'd0);
    for (int k = 1; k <= 15; k++) begin
      step(k < 3, 1'b0, 16'd5, 16'd0);
      if (k <= 11) exp_period(k, 2, 5, s, b, q);
      else begin
        s = 1'b0;
        b = 1'b0;
        q = 1'b0;
      end
      check_all($sformatf("stop k=%0d", k), s, b, (k >= 2) && (k <= 11), 1'b0, q);
    end

    // Enable dropped during DELAY returns to IDLE straight away.
    setup(16'd2, 16'd5);
    for (int k = 1; k <= 6; k++) begin
      step(k < 3, 1'b0, 16'd2, 16'd5);
      check_all($sformatf("dly stop k=%0d", k), 1'b0, 1'b0, (k == 2) || (k == 3), 1'b0, 1'b0);
    end

    // Reset in the first RUN_LOW cycle while chopper_sig is still high.
    setup(16'd4, 16'd0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0, 16'd4, 16'd0);
      exp_period(k, 2, 4, s, b, q);
      check_all($sformatf("prerst k=%0d", k), s, b, k >= 2, 1'b0, q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_all("midrst async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("midrst held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Config was cleared by reset, so the fresh run uses Ne=1.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("postrst k=1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k <= 7; k++) begin
      step(1'b1, 1'b0, 16'd4, 16'd0);
      exp_period(k, 2, 1, s, b, q);
      check_all($sformatf("postrst k=%0d", k), s, b, 1'b1, 1'b0, q);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
